// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE/RUN/HALTED control, PC update and a 16-entry branch-target LUT.
// Optional retired-instruction counter on the InstrCount port when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            Branch,
    input  logic            Halt,
    input  logic [3:0]      TargetIdx,
    input  logic            LutWrEn,
    input  logic [3:0]      LutAddr,
    input  logic [PC_W-1:0] LutData,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]     InstrCount
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;
    logic            start_acc_s;
    logic            running_r;
    logic            done_r;
    logic [PC_W-1:0] lut_r [LUT_DEPTH];

    // Next-state and next-PC selection; Halt outranks Branch, Start only counts outside RUN
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        start_acc_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALTED: begin
                if (Start) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = StartAddr;
                    start_acc_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                    pc_nxt_s    = pc_r;
                end
            end
            ST_RUN: begin
                if (Halt) begin
                    state_nxt_s = ST_HALTED;
                    pc_nxt_s    = pc_r;
                end else if (Branch) begin
                    pc_nxt_s    = lut_r[TargetIdx];
                end else begin
                    pc_nxt_s    = pc_r + PC_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = '0;
            end
        endcase
    end

    // State, PC and status flags; flags decode the next state so they line up with state_r
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= '0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
            done_r    <= (state_nxt_s == ST_HALTED);
        end
    end

    // Branch-target table; a same-cycle branch read sees the pre-write entry
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_r[i] <= '0;
            end
        end else if (LutWrEn) begin
            lut_r[LutAddr] <= LutData;
        end else begin
            lut_r[LutAddr] <= lut_r[LutAddr];
        end
    end

    assign ProgCtr = pc_r;
    assign Running = running_r;
    assign Done    = done_r;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_r;

    // Retired-instruction count: every RUN cycle including the halting one, saturating
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_r <= 16'd0;
        end else if (start_acc_s) begin
            cnt_r <= 16'd0;
        end else if ((state_r == ST_RUN) && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign InstrCount = cnt_r;
`else
    logic unused_start_acc_s;
    assign unused_start_acc_s = start_acc_s;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model pushes expected PC/flags per cycle,
// popped and compared half a cycle after each rising edge.
module tb_fetch_unit;

    logic       Clk;
    logic       Reset_n;
    logic       Start;
    logic [9:0] StartAddr;
    logic       Branch;
    logic       Halt;
    logic [3:0] TargetIdx;
    logic       LutWrEn;
    logic [3:0] LutAddr;
    logic [9:0] LutData;
    logic [9:0] ProgCtr;
    logic       Running;
    logic       Done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] InstrCount;
`endif

    fetch_unit #(.PC_W(10), .LUT_DEPTH(16)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Branch    (Branch),
        .Halt      (Halt),
        .TargetIdx (TargetIdx),
        .LutWrEn   (LutWrEn),
        .LutAddr   (LutAddr),
        .LutData   (LutData),
        .ProgCtr   (ProgCtr),
        .Running   (Running),
        .Done      (Done)
`ifdef FETCH_PERF_CNT_EN
        ,
        .InstrCount(InstrCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0]  pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q [$];
    int          checks;
    int          errors;

    int          m_state;
    logic [9:0]  m_pc;
    logic [9:0]  m_lut [16];
    logic [15:0] m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 10'd0;
        m_cnt   = 16'd0;
        for (int i = 0; i < 16; i++) m_lut[i] = 10'd0;
    endtask

    // One clock cycle: drive inputs, predict, clock, then pop and compare
    task automatic cycle(input string tag, input logic st, input logic [9:0] sa,
                         input logic br, input logic ha, input logic [3:0] ti,
                         input logic we, input logic [3:0] wa, input logic [9:0] wd);
        exp_t       e;
        exp_t       got;
        int         n_state;
        logic [9:0] n_pc;
        logic       acc;
        Start = st; StartAddr = sa; Branch = br; Halt = ha; TargetIdx = ti;
        LutWrEn = we; LutAddr = wa; LutData = wd;
        n_state = m_state;
        n_pc    = m_pc;
        acc     = 1'b0;
        if (m_state != 1 && st) begin
            n_state = 1; n_pc = sa; acc = 1'b1;
        end else if (m_state == 1) begin
            if (ha)      n_state = 2;
            else if (br) n_pc = m_lut[ti];
            else         n_pc = m_pc + 10'd1;
        end
        if (acc)                                  m_cnt = 16'd0;
        else if (m_state == 1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (we) m_lut[wa] = wd;
        m_state = n_state;
        m_pc    = n_pc;
        e.pc = m_pc; e.run = (m_state == 1); e.done = (m_state == 2); e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        check_val({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check_val({tag, "_pc"},   ProgCtr, got.pc);
            check_val({tag, "_run"},  Running, got.run);
            check_val({tag, "_done"}, Done,    got.done);
            check_val({tag, "_excl"}, Running & Done, 0);
`ifdef FETCH_PERF_CNT_EN
            check_val({tag, "_cnt"},  InstrCount, got.cnt);
`endif
        end
    endtask

    task automatic plain(input string tag);
        cycle(tag, 1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 10'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_pc"},   ProgCtr, 0);
        check_val({tag, "_run"},  Running, 0);
        check_val({tag, "_done"}, Done,    0);
`ifdef FETCH_PERF_CNT_EN
        check_val({tag, "_cnt"},  InstrCount, 0);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset_n = 1'b0;
        Start = 1'b0; StartAddr = 10'd0; Branch = 1'b0; Halt = 1'b0; TargetIdx = 4'd0;
        LutWrEn = 1'b0; LutAddr = 4'd0; LutData = 10'd0;
        model_reset();
        #1;
        check_reset_state("por");
        @(negedge Clk);
        Reset_n = 1'b1;

        // IDLE holds and ignores Branch/Halt
        plain("idle_hold");
        cycle("idle_brhalt", 1'b0, 10'd0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 10'd0);

        // Start at 5 then sequential fetch
        cycle("start5", 1'b1, 10'd5, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 10'd0);
        check_val("start5_const", ProgCtr, 5);
        plain("seq6");
        plain("seq7");
        plain("seq8");
        check_val("seq8_const", ProgCtr, 8);
        check_val("seq8_running", Running, 1);

        // Start in RUN ignored; LUT[3]=200 written while running
        cycle("start_in_run", 1'b1, 10'd100, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 10'd200);
        check_val("start_in_run_const", ProgCtr, 9);
        plain("seq10");
        cycle("branch3", 1'b0, 10'd0, 1'b1, 1'b0, 4'd3, 1'b0, 4'd0, 10'd0);
        check_val("branch3_const", ProgCtr, 200);
        plain("after_branch");
        check_val("after_branch_const", ProgCtr, 201);

        // Write/read collision on LUT[2]
        cycle("wr_lut2_old", 1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 10'd9);
        cycle("collide", 1'b0, 10'd0, 1'b1, 1'b0, 4'd2, 1'b1, 4'd2, 10'd77);
        check_val("collide_const", ProgCtr, 9);
        cycle("rebranch2", 1'b0, 10'd0, 1'b1, 1'b0, 4'd2, 1'b0, 4'd0, 10'd0);
        check_val("rebranch2_const", ProgCtr, 77);

        // Reach PC 40, then Halt with Branch
        cycle("wr_lut5", 1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 10'd40);
        cycle("to40", 1'b0, 10'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd0, 10'd0);
        cycle("halt_br", 1'b0, 10'd0, 1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 10'd0);
        check_val("halt_pc_const", ProgCtr, 40);
        check_val("halt_done_const", Done, 1);
        cycle("halted_ignore", 1'b0, 10'd0, 1'b1, 1'b1, 4'd3, 1'b1, 4'd7, 10'd300);
        plain("halted_hold");

        // Restart at 0; four RUN cycles then halt gives a count of five
        cycle("restart0", 1'b1, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 10'd0);
        check_val("restart0_done", Done, 0);
        for (int i = 0; i < 4; i++) plain("cnt_run");
        cycle("cnt_halt", 1'b0, 10'd0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 10'd0);
`ifdef FETCH_PERF_CNT_EN
        check_val("cnt_five_const", InstrCount, 5);
`endif

        // PC wrap from all-ones
        cycle("start1023", 1'b1, 10'd1023, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 10'd0);
        plain("wrap");
        check_val("wrap_const", ProgCtr, 0);

        // Reach PC 50 then asynchronous reset mid-RUN
        cycle("wr_lut6", 1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd6, 10'd50);
        cycle("to50", 1'b0, 10'd0, 1'b1, 1'b0, 4'd6, 1'b0, 4'd0, 10'd0);
        check_val("to50_const", ProgCtr, 50);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("async_rst");
        #1;
        Reset_n = 1'b1;
        plain("post_rst_idle");
        cycle("post_rst_start", 1'b1, 10'd3, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 10'd0);
        cycle("lut_cleared", 1'b0, 10'd0, 1'b1, 1'b0, 4'd6, 1'b0, 4'd0, 10'd0);

        // Random mixed traffic against the model
        for (int i = 0; i < 200; i++) begin
            cycle("rand", ($urandom_range(0, 15) == 0), 10'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                  4'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom), 10'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
